register_file_32x32: RTL and testbench

- 32-entry × 32-bit register file with two read ports and one write port.
- Sits directly downstream of the 5-bit write-address decoder and consumes its 32-bit one-hot output as per-register write enables.
- Read ports are registered: read data appears one cycle after the address.
- Same-cycle write-to-read bypass is included, so the datapath always sees the newest value.

---
 rtl/register_file_32x32_if.sv | 29 ++
 rtl/register_file_32x32.sv | 105 ++++++++++
 tb/tb_register_file_32x32.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/register_file_32x32_if.sv
// Bus bundle for register_file_32x32.
//   master : drives the write port (wr_en/wr_sel/wr_data) and the read
//            request (rd_en/rd_addr_a/rd_addr_b); receives read data,
//            rd_valid and the sticky sel_error flag.
//   slave  : the register file side of the same bundle.
interface register_file_32x32_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wr_en;
  logic [31:0]           wr_sel;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [4:0]            rd_addr_a;
  logic [4:0]            rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  rd_valid;
  logic                  sel_error;

  modport master (
    output wr_en, wr_sel, wr_data, rd_en, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, rd_valid, sel_error
  );

  modport slave (
    input  wr_en, wr_sel, wr_data, rd_en, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, rd_valid, sel_error
  );
endinterface

// File: rtl/register_file_32x32.sv
// 32 x DATA_WIDTH register file, one write port (one-hot select from the
// upstream address decoder), two registered read ports with write-first
// bypass.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : register_file_32x32_if.slave (write, read, status)
// Optional hardwired-zero register 0 (ZERO_REG).

// One registered read port. Bypass selects the in-flight write data when
// the port reads the register being written at this edge.
module register_file_32x32_rd #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rd_en,
  input  logic [4:0]                  addr,
  input  logic [31:0][DATA_WIDTH-1:0] mem,
  input  logic                        byp_ok,
  input  logic [4:0]                  wr_idx,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  output logic [DATA_WIDTH-1:0]       rd_data
);
  always_ff @(posedge clk) begin
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= (byp_ok && (wr_idx == addr)) ? wr_data : mem[addr];
  end
endmodule

module register_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  register_file_32x32_if.slave    bus
);
  localparam int NUM_PORTS = 2;

  logic [31:0][DATA_WIDTH-1:0]        mem;
  logic                               sel_nz, sel_multi, wr_legal;
  logic [4:0]                         wr_idx;
  logic                               byp_ok;
  logic [NUM_PORTS-1:0][4:0]          rd_addr;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_q;
  logic                               rd_valid_q, sel_error_q;

  // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
  assign sel_nz    = |bus.wr_sel;
  assign sel_multi = |(bus.wr_sel & (bus.wr_sel - 32'd1));
  assign wr_legal  = bus.wr_en & sel_nz & ~sel_multi;

  // One-hot to index; only meaningful when wr_legal (exactly one bit set).
  always_comb begin
    wr_idx = '0;
    for (int k = 0; k < 32; k++)
      if (bus.wr_sel[k]) wr_idx = wr_idx | 5'(k);
  end

  // A discarded write to the zero register must not bypass either.
  assign byp_ok = wr_legal && !((ZERO_REG != 0) && (wr_idx == 5'd0));

  // Register 0 under ZERO_REG is never written, so it stays at its reset 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '0;
    end else if (wr_legal) begin
      for (int i = 0; i < 32; i++)
        if (bus.wr_sel[i] && !((ZERO_REG != 0) && (i == 0)))
          mem[i] <= bus.wr_data;
    end
  end

  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    register_file_32x32_rd #(.DATA_WIDTH(DATA_WIDTH)) u_rd (
      .clk     (clk),
      .reset   (reset),
      .rd_en   (bus.rd_en),
      .addr    (rd_addr[p]),
      .mem     (mem),
      .byp_ok  (byp_ok),
      .wr_idx  (wr_idx),
      .wr_data (bus.wr_data),
      .rd_data (rd_q[p])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      sel_error_q <= 1'b0;
    end else begin
      rd_valid_q  <= bus.rd_en;
      if (bus.wr_en && !wr_legal) sel_error_q <= 1'b1;
    end
  end

  assign bus.rd_data_a = rd_q[0];
  assign bus.rd_data_b = rd_q[1];
  assign bus.rd_valid  = rd_valid_q;
  assign bus.sel_error = sel_error_q;
endmodule

// File: tb/tb_register_file_32x32.sv
module tb_register_file_32x32;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  register_file_32x32_if #(.DATA_WIDTH(32)) bus();

  register_file_32x32 #(.DATA_WIDTH(32), .ZERO_REG(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference: memory array plus output registers; write-first read is
  // modelled as "apply the write, then read the updated array".
  logic [31:0] m_mem [32];
  logic [31:0] m_a, m_b;
  logic        m_vld, m_err;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_edge();
    bit legal;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_a = '0; m_b = '0; m_vld = 1'b0; m_err = 1'b0;
    end else begin
      legal = bus.wr_en && ($countones(bus.wr_sel) == 1);
      if (bus.wr_en && !legal) m_err = 1'b1;
      if (legal)
        for (int i = 1; i < 32; i++)
          if (bus.wr_sel[i]) m_mem[i] = bus.wr_data;
      m_vld = bus.rd_en;
      if (bus.rd_en) begin
        m_a = m_mem[bus.rd_addr_a];
        m_b = m_mem[bus.rd_addr_b];
      end
    end
  endtask

  // One clock: update model at the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("rd_valid",  {31'd0, bus.rd_valid},  {31'd0, m_vld});
    chk("sel_error", {31'd0, bus.sel_error}, {31'd0, m_err});
    chk("rd_data_a", bus.rd_data_a, m_a);
    chk("rd_data_b", bus.rd_data_b, m_b);
  endtask

  task automatic drive(input logic wen, input logic [31:0] sel, input logic [31:0] data,
                       input logic ren, input logic [4:0] aa, input logic [4:0] ab);
    bus.wr_en = wen; bus.wr_sel = sel; bus.wr_data = data;
    bus.rd_en = ren; bus.rd_addr_a = aa; bus.rd_addr_b = ab;
    cyc();
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    logic [31:0] sel;
    bus.wr_en = 0; bus.wr_sel = 0; bus.wr_data = 0;
    bus.rd_en = 0; bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_a = '0; m_b = '0; m_vld = 0; m_err = 0;

    // Reset for two cycles, then read.
    reset = 1'b1; cyc(); cyc();
    chk("rst_valid", {31'd0, bus.rd_valid}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 5'd31);
    chk("rst_rd_vld", {31'd0, bus.rd_valid}, 32'd1);
    chk("rst_rd_a",   bus.rd_data_a, 32'd0);
    chk("rst_rd_b",   bus.rd_data_b, 32'd0);
    chk("rst_err",    {31'd0, bus.sel_error}, 32'd0);
    idle();
    chk("idle_vld", {31'd0, bus.rd_valid}, 32'd0);

    // Write / readback of reg 7.
    drive(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd7, 5'd7);
    chk("wb_a", bus.rd_data_a, 32'hDEAD_BEEF);
    chk("wb_b", bus.rd_data_b, 32'hDEAD_BEEF);

    // Bypass on port A, plain read on port B.
    drive(1'b1, 32'd1 << 12, 32'h1111, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 32'd1 << 3,  32'h3333, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 32'd1 << 12, 32'h2222, 1'b1, 5'd12, 5'd3);
    chk("byp_a", bus.rd_data_a, 32'h2222);
    chk("byp_b", bus.rd_data_b, 32'h3333);
    // Both ports bypassing the same write.
    drive(1'b1, 32'd1 << 9, 32'h9999, 1'b1, 5'd9, 5'd9);
    chk("byp2_a", bus.rd_data_a, 32'h9999);
    chk("byp2_b", bus.rd_data_b, 32'h9999);

    // Zero register: discarded write, no bypass.
    drive(1'b1, 32'd1, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0);
    chk("zero_byp", bus.rd_data_a, 32'd0);
    chk("zero_err", {31'd0, bus.sel_error}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 5'd7);
    chk("zero_rd", bus.rd_data_a, 32'd0);

    // Illegal selects.
    drive(1'b1, 32'd1 << 1, 32'h11, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 32'd1 << 2, 32'h22, 1'b0, 5'd0, 5'd0);
    drive(1'b1, 32'h0000_0006, 32'hABCD, 1'b0, 5'd0, 5'd0);
    chk("ill_err", {31'd0, bus.sel_error}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 5'd2);
    chk("ill_r1", bus.rd_data_a, 32'h11);
    chk("ill_r2", bus.rd_data_b, 32'h22);
    idle(); idle();
    chk("ill_sticky", {31'd0, bus.sel_error}, 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("ill_clr", {31'd0, bus.sel_error}, 32'd0);
    drive(1'b1, 32'd0, 32'hABCD, 1'b1, 5'd1, 5'd2);
    chk("zsel_err", {31'd0, bus.sel_error}, 32'd1);
    chk("zsel_r1", bus.rd_data_a, 32'd0);
    idle();
    chk("zsel_sticky", {31'd0, bus.sel_error}, 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0;

    // Full sweep via port B.
    for (int i = 1; i < 32; i++)
      drive(1'b1, 32'd1 << i, 32'h100 + i, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd0, 5'(i));
      chk("sweep", bus.rd_data_b, (i == 0) ? 32'd0 : 32'h100 + i);
    end

    // Reset in the cycle after a read strobe.
    drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd20, 5'd21);
    bus.rd_en = 1'b1; bus.rd_addr_a = 5'd22; bus.rd_addr_b = 5'd23;
    reset = 1'b1; cyc(); reset = 1'b0;
    chk("mrst_vld", {31'd0, bus.rd_valid}, 32'd0);
    chk("mrst_a",   bus.rd_data_a, 32'd0);
    chk("mrst_b",   bus.rd_data_b, 32'd0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 32'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i));
      chk("post_rst", bus.rd_data_a | bus.rd_data_b, 32'd0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 90) sel = 32'd1 << $urandom_range(0, 31);
      else if ($urandom_range(0, 1) == 0) sel = 32'd0;
      else sel = $urandom();
      reset = ($urandom_range(0, 79) == 0);
      drive(1'($urandom_range(0, 1)), sel, $urandom(), 1'($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end
endmodule
